// File: rtl/mdu_pkg.sv
// Shared definitions for the HI/LO multiply unit: op encodings, FSM state
// type and the MULT operand magnitude helper.
package mdu_pkg;

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_MTHI  = 3'b011;
  localparam logic [2:0] OP_MTLO  = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } mdu_state_e;

  // 0x80000000 maps to itself, which is the correct unsigned magnitude.
  function automatic logic [31:0] mag32(input logic [31:0] x);
    return x[31] ? (~x + 32'd1) : x;
  endfunction

endpackage

// File: rtl/mdu_ctrl_mul_core.sv
// 32-iteration shift-add unsigned multiplier; one iteration per non-stalled
// clock after the start pulse, finish is asserted on the 32nd iteration edge.
module mul_core
  import mdu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        cpu_stall,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] product,
  output logic        busy,
  output logic        finish
);

  logic [63:0] r_mcand;
  logic [63:0] r_acc;
  logic [31:0] r_mplier;
  logic [4:0]  r_cnt;
  logic        r_busy;
  logic        w_step;

  assign w_step  = r_busy & ~cpu_stall;
  assign finish  = w_step & (r_cnt == 5'd31);
  assign product = r_acc;
  assign busy    = r_busy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mcand  <= '0;
      r_acc    <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
    end else if (start) begin
      r_mcand  <= {32'd0, a};
      r_mplier <= b;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b1;
    end else if (w_step) begin
      if (r_mplier[0]) r_acc <= r_acc + r_mcand;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + 5'd1;
      if (r_cnt == 5'd31) r_busy <= 1'b0;
    end
  end

endmodule

// File: rtl/mdu_ctrl.sv
// HI/LO controller: accepts MULT/MULTU/MTHI/MTLO, sign-conditions operands
// for the unsigned core, stores HI/LO and raises the pipeline stall request.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int unsigned OP_W = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            op_valid,
  input  logic [OP_W-1:0] op,
  input  logic [31:0]     rs_val,
  input  logic [31:0]     rt_val,
  input  logic            rd_hilo,
  input  logic            cpu_stall,
  output logic [31:0]     hi,
  output logic [31:0]     lo,
  output logic            busy,
  output logic            stall_req,
  output logic            done
);

  mdu_state_e  r_state;
  logic        r_neg;
  logic        r_done;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic        w_is_mult;
  logic        w_is_multu;
  logic        w_is_mthi;
  logic        w_is_mtlo;
  logic        w_known;
  logic        w_busy;
  logic        w_accept;
  logic        w_start;
  logic [31:0] w_core_a;
  logic [31:0] w_core_b;
  logic [63:0] w_prod;
  logic [63:0] w_result;
  logic        w_core_busy;
  logic        w_finish;

  assign w_is_mult  = (op == OP_W'(OP_MULT));
  assign w_is_multu = (op == OP_W'(OP_MULTU));
  assign w_is_mthi  = (op == OP_W'(OP_MTHI));
  assign w_is_mtlo  = (op == OP_W'(OP_MTLO));

  // Unknown codes never count as a HI/LO op, so they cannot cause a stall.
  assign w_known  = op_valid & (w_is_mult | w_is_multu | w_is_mthi | w_is_mtlo);
  assign w_busy   = (r_state != ST_IDLE) | w_core_busy;
  assign w_accept = w_known & ~w_busy & ~cpu_stall;
  assign w_start  = w_accept & (w_is_mult | w_is_multu);

  always_comb begin
    w_core_a = rs_val;
    w_core_b = rt_val;
    if (w_is_mult) begin
      w_core_a = mag32(rs_val);
      w_core_b = mag32(rt_val);
    end
  end

  mul_core u_core (
    .clk       (clk),
    .reset     (reset),
    .start     (w_start),
    .cpu_stall (cpu_stall),
    .a         (w_core_a),
    .b         (w_core_b),
    .product   (w_prod),
    .busy      (w_core_busy),
    .finish    (w_finish)
  );

  assign w_result = r_neg ? (~w_prod + 64'd1) : w_prod;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_neg   <= 1'b0;
      r_done  <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_neg   <= w_is_mult & (rs_val[31] ^ rt_val[31]);
            r_state <= ST_RUN;
          end
          if (w_accept && w_is_mthi) r_hi <= rs_val;
          if (w_accept && w_is_mtlo) r_lo <= rs_val;
        end
        ST_RUN: begin
          if (w_finish) r_state <= ST_FIX;
        end
        ST_FIX: begin
          if (!cpu_stall) begin
            {r_hi, r_lo} <= w_result;
            r_done       <= 1'b1;
            r_state      <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign hi        = r_hi;
  assign lo        = r_lo;
  assign busy      = w_busy;
  assign done      = r_done;
  assign stall_req = w_busy & (w_known | rd_hilo) & ~reset;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: table of single-op vectors plus hand-written
// stall, hazard and mid-run reset sequences.
module tb_mdu_ctrl;

  logic        clk;
  logic        reset;
  logic        op_valid;
  logic [2:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        rd_hilo;
  logic        cpu_stall;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        stall_req;
  logic        done;

  int n_run  = 0;
  int n_fail = 0;
  logic [31:0] model_hi = '0;
  logic [31:0] model_lo = '0;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        is_mul;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[10];

  mdu_ctrl #(.OP_W(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .op_valid  (op_valid),
    .op        (op),
    .rs_val    (rs_val),
    .rt_val    (rt_val),
    .rd_hilo   (rd_hilo),
    .cpu_stall (cpu_stall),
    .hi        (hi),
    .lo        (lo),
    .busy      (busy),
    .stall_req (stall_req),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    @(negedge clk);
    op_valid = 1'b1; op = v.op; rs_val = v.rs; rt_val = v.rt;
    @(negedge clk);
    op_valid = 1'b0;
    if (v.is_mul) begin
      check({v.name, "_busy_e0"}, busy, 1);
      repeat (32) @(negedge clk);
      check({v.name, "_nodone_e32"}, done, 0);
      check({v.name, "_hold_e32"}, {hi, lo}, {model_hi, model_lo});
      @(negedge clk);
      check({v.name, "_done_e33"}, done, 1);
      check({v.name, "_busy_e33"}, busy, 0);
      check({v.name, "_hilo"}, {hi, lo}, {v.hi, v.lo});
      @(negedge clk);
      check({v.name, "_done_pulse"}, done, 0);
    end else begin
      check({v.name, "_hilo"}, {hi, lo}, {v.hi, v.lo});
      check({v.name, "_busy"}, busy, 0);
      check({v.name, "_done"}, done, 0);
    end
    model_hi = v.hi;
    model_lo = v.lo;
  endtask

  initial begin
    int errs;
    int pulses;
    vec_t fin;

    vecs[0] = '{"multu_max", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFE, 32'h00000001};
    vecs[1] = '{"mult_m3x7", 3'b001, 32'hFFFFFFFD, 32'h00000007, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[2] = '{"mult_min",  3'b001, 32'h80000000, 32'h80000000, 1'b1, 32'h40000000, 32'h00000000};
    vecs[3] = '{"mult_7xm1", 3'b001, 32'h00000007, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFF9};
    vecs[4] = '{"mult_negneg", 3'b001, 32'hFFFFFFFB, 32'hFFFFFFFC, 1'b1, 32'h00000000, 32'h00000014};
    vecs[5] = '{"mthi",      3'b011, 32'hDEADBEEF, 32'h00000000, 1'b0, 32'hDEADBEEF, 32'h00000014};
    vecs[6] = '{"mtlo",      3'b100, 32'hCAFEF00D, 32'h00000000, 1'b0, 32'hDEADBEEF, 32'hCAFEF00D};
    vecs[7] = '{"noop",      3'b111, 32'h00000001, 32'h00000002, 1'b0, 32'hDEADBEEF, 32'hCAFEF00D};
    vecs[8] = '{"mult_zero_neg", 3'b001, 32'h00000000, 32'h80000000, 1'b1, 32'h00000000, 32'h00000000};
    vecs[9] = '{"multu_hi",  3'b010, 32'h80000000, 32'h00000002, 1'b1, 32'h00000001, 32'h00000000};

    reset = 1'b1; op_valid = 1'b1; op = 3'b001; rs_val = '0; rt_val = '0;
    rd_hilo = 1'b1; cpu_stall = 1'b0;
    #12;
    check("rst_hilo", {hi, lo}, 64'd0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_stall_req", stall_req, 0);
    @(negedge clk);
    reset = 1'b0; op_valid = 1'b0; rd_hilo = 1'b0;

    for (int i = 0; i < 10; i++) run_vec(vecs[i]);

    // MULTU 5x6 with four stalled cycles after E10: done lands on E37.
    @(negedge clk);
    op_valid = 1'b1; op = 3'b010; rs_val = 32'd5; rt_val = 32'd6;
    @(negedge clk);
    op_valid = 1'b0;
    repeat (10) @(negedge clk);
    cpu_stall = 1'b1;
    repeat (4) @(negedge clk);
    check("stall_busy", busy, 1);
    cpu_stall = 1'b0;
    repeat (22) @(negedge clk);
    check("stall_nodone_e36", done, 0);
    check("stall_hold_e36", {hi, lo}, {model_hi, model_lo});
    @(negedge clk);
    check("stall_done_e37", done, 1);
    check("stall_hilo", {hi, lo}, {32'd0, 32'd30});
    model_hi = 32'd0; model_lo = 32'd30;

    // Hazard: rd_hilo and a pending MTLO during a MULTU 2x3.
    @(negedge clk);
    op_valid = 1'b1; op = 3'b010; rs_val = 32'd2; rt_val = 32'd3;
    @(negedge clk);
    op = 3'b100; rs_val = 32'h00001234; rd_hilo = 1'b1;
    errs = 0;
    for (int c = 0; c < 33; c++) begin
      if (stall_req !== 1'b1 || busy !== 1'b1) errs++;
      if (c < 32) @(negedge clk);
    end
    check("haz_stall_req_busy", errs, 0);
    check("haz_lo_hold_e32", lo, 32'd30);
    @(negedge clk);
    check("haz_done_e33", done, 1);
    check("haz_stall_req_e33", stall_req, 0);
    check("haz_lo_prod", {hi, lo}, {32'd0, 32'd6});
    @(negedge clk);
    check("haz_mtlo_accepted", lo, 32'h00001234);
    check("haz_mtlo_nodone", done, 0);
    op_valid = 1'b0; rd_hilo = 1'b0;

    // Reset pulsed at E10 of a MULT discards the product.
    @(negedge clk);
    op_valid = 1'b1; op = 3'b001; rs_val = 32'hFFFFFFFD; rt_val = 32'd7;
    @(negedge clk);
    op_valid = 1'b0; rd_hilo = 1'b1;
    repeat (10) @(negedge clk);
    check("rrun_stall_req", stall_req, 1);
    reset = 1'b1;
    #1;
    check("rrun_hilo", {hi, lo}, 64'd0);
    check("rrun_busy", busy, 0);
    check("rrun_stall_req", stall_req, 0);
    @(negedge clk);
    reset = 1'b0; rd_hilo = 1'b0;
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
    end
    check("rrun_no_done", pulses, 0);
    check("rrun_hilo_after", {hi, lo}, 64'd0);
    model_hi = '0; model_lo = '0;
    fin = '{"post_rst_multu", 3'b010, 32'd2, 32'd3, 1'b1, 32'd0, 32'd6};
    run_vec(fin);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 SHALL have parameter OP_W, default 3, meaning width of the op field.
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port op_valid  input  1  EX stage presents a HI/LO-class instruction.
REQ-005 SHALL have port op  input  OP_W  encoding: 001 MULT, 010 MULTU, 011 MTHI, 100 MTLO; all other codes are no-op.
REQ-006 SHALL have port rs_val  input  32  first operand; also the MTHI/MTLO source.
REQ-007 SHALL have port rt_val  input  32  second operand.
REQ-008 SHALL have port rd_hilo  input  1  MFHI/MFLO present in EX.
REQ-009 SHALL have port cpu_stall  input  1  pipeline frozen this cycle.
REQ-010 SHALL have ports hi and lo, each output 32, carrying the architectural HI/LO registers.
REQ-011 SHALL have port busy  output  1  multiply in flight.
REQ-012 SHALL have port stall_req  output  1  combinational stall request to the hazard unit.
REQ-013 SHALL have port done  output  1  one-cycle pulse when HI/LO receive a product.

Function
REQ-014 SHALL implement the FSM states IDLE, RUN and FIX; busy SHALL be 1 in RUN and FIX.
REQ-015 SHALL accept an op only when op_valid=1, busy=0 and cpu_stall=0.
REQ-016 On accepting MULT or MULTU in IDLE, SHALL pulse the core start, latch the operands and move to RUN on that edge (edge E0).
REQ-017 For MULTU, SHALL pass the operands unchanged to the core.
REQ-018 For MULT, SHALL pass the magnitudes |rs_val| and |rt_val| to the core and latch neg = rs_val[31] XOR rt_val[31].
REQ-019 SHALL treat 0x80000000 as magnitude 0x80000000 (unsigned) for the MULT magnitude rule.
REQ-020 In RUN, SHALL advance one core iteration on each edge where cpu_stall=0, and hold all state where cpu_stall=1.
REQ-021 SHALL move RUN->FIX on the core finish, after 32 non-stalled iterations (E1..E32).
REQ-022 In FIX, on the next non-stalled edge (E33), SHALL write {hi,lo} = neg ? two's-complement 64-bit negation of the core product : core product.
REQ-023 In FIX, on that same E33 edge, SHALL pulse done for one cycle and return to IDLE.
REQ-024 SHALL make the minimum latency from accept to updated hi/lo 33 edges, extended by 1 edge per stalled cycle.
REQ-025 MTHI/MTLO accepted in IDLE SHALL write hi or lo from rs_val on the accepting edge, with no FSM transition and no done pulse.
REQ-026 SHALL assert stall_req = busy & (op_valid | rd_hilo); the op SHALL NOT be accepted while stall_req=1.
REQ-027 When a multiply completes in the same cycle that a new op_valid is presented, the new op SHALL be accepted on the first edge after busy falls, never on E33 itself.
REQ-028 SHALL keep hi/lo holding their previous values for the entire multiply until E33.
REQ-029 SHALL ignore no-op codes entirely: no stall, no state change.

Reset
REQ-030 reset SHALL asynchronously force the state to IDLE, hi=0, lo=0, busy=0, done=0, neg=0 and the core registers to 0, including during RUN/FIX; the aborted product SHALL be discarded.
REQ-031 stall_req SHALL be 0 while reset=1.

Structure
REQ-032 The op encodings and the state enum SHALL reside in the shared package mdu_pkg.
REQ-033 SHALL instantiate exactly one sub-module, mul_core: a 32-iteration shift-add unsigned multiplier with start, cpu_stall, 64-bit product, busy and finish.
REQ-034 Sign conditioning, HI/LO storage and the hazard logic SHALL reside in mdu_ctrl.

Verification
REQ-035 MULTU 0xFFFFFFFF x 0xFFFFFFFF, no stalls -> done at E33; hi=0xFFFFFFFE, lo=0x00000001.
REQ-036 MULT 0xFFFFFFFD (-3) x 0x00000007 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; MULT 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0.
REQ-037 MULTU 5 x 6 with cpu_stall high for 4 cycles mid-RUN -> done at E37; hi=0, lo=30; hi/lo unchanged before E37.
REQ-038 rd_hilo=1 during RUN -> stall_req=1 every busy cycle; 0 on the cycle after done; MTLO 0x1234 presented while busy is held off, then accepted afterwards, giving lo=0x1234.
REQ-039 reset pulsed at E10 of a MULT -> hi=lo=0, busy=0, no done pulse; a following MULTU 2 x 3 -> lo=6.
